// File: rtl/pipe_ctrl_if.sv
// Pipeline control bus: per-stage stall requests and redirect/multicycle events in,
// stall/bubble/flush controls and multicycle status out.
interface pipe_ctrl_if #(
  parameter int unsigned STAGES   = 5,
  parameter int unsigned MC_CNT_W = 6
);
  logic [STAGES-1:0]   stallreq;
  logic                br_flush;
  logic                mc_start;
  logic                mc_done;
  logic [STAGES:0]     stall;
  logic [STAGES-1:0]   bubble;
  logic [STAGES-1:0]   flush;
  logic [STAGES-1:0]   stage_valid;
  logic                mc_busy;
  logic [MC_CNT_W-1:0] mc_cnt;
  logic                mc_timeout;

  // Pipeline side: raises requests, consumes controls.
  modport master (
    output stallreq, br_flush, mc_start, mc_done,
    input  stall, bubble, flush, stage_valid, mc_busy, mc_cnt, mc_timeout
  );

  // Controller side.
  modport slave (
    input  stallreq, br_flush, mc_start, mc_done,
    output stall, bubble, flush, stage_valid, mc_busy, mc_cnt, mc_timeout
  );
endinterface

// File: rtl/pipe_ctrl.sv
// In-order pipeline hazard controller: stall/bubble generation, branch flush with
// deferral under stall, per-stage valid tracking and a multicycle-op watchdog.
module pipe_ctrl #(
  parameter int unsigned STAGES      = 5,
  parameter int unsigned FLUSH_DEPTH = 1,
  parameter int unsigned MC_STAGE    = 3,
  parameter int unsigned MC_TIMEOUT  = 40,
  parameter int unsigned MC_CNT_W    = 6
) (
  input logic        clk,
  input logic        rst,
  pipe_ctrl_if.slave bus
);

  localparam logic [MC_CNT_W-1:0] TimeoutVal = MC_CNT_W'(MC_TIMEOUT);
  localparam logic [MC_CNT_W-1:0] LastVal    = MC_CNT_W'(MC_TIMEOUT - 1);

  logic [STAGES-1:0]   eff_req;
  logic [STAGES:0]     stall_c;
  logic                stall_acc;
  logic [STAGES-1:0]   bubble_c;
  logic [STAGES-1:0]   flush_c;
  logic [STAGES-1:0]   flush_mask;
  logic                flush_apply;
  logic [STAGES-1:0]   prev_valid;

  logic [STAGES-1:0]   valid_q, valid_d;
  logic                flush_pend_q, flush_pend_d;
  logic                mc_busy_q, mc_busy_d;
  logic [MC_CNT_W-1:0] mc_cnt_q, mc_cnt_d;
  logic                mc_timeout_q, mc_timeout_d;

  // Gating with rst keeps every combinational control low while reset is held.
  always_comb begin
    eff_req = bus.stallreq;
    eff_req[MC_STAGE-1] = bus.stallreq[MC_STAGE-1] | mc_busy_q;
    if (rst) eff_req = '0;
  end

  // A stall at stage s freezes everything upstream of it, including the PC.
  always_comb begin
    stall_acc = 1'b0;
    stall_c   = '0;
    for (int j = STAGES; j >= 1; j--) begin
      stall_acc  = stall_acc | eff_req[j-1];
      stall_c[j] = stall_acc;
    end
    stall_c[0] = stall_acc;
  end

  always_comb begin
    bubble_c = '0;
    for (int i = 0; i < STAGES; i++) begin
      bubble_c[i] = stall_c[i] & ~stall_c[i+1];
    end
  end

  always_comb begin
    flush_mask = '0;
    for (int i = 0; i < FLUSH_DEPTH; i++) begin
      flush_mask[i] = 1'b1;
    end
    flush_apply = ~rst & (bus.br_flush | flush_pend_q) & ~stall_c[FLUSH_DEPTH];
    flush_c     = flush_apply ? flush_mask : '0;
  end

  // A redirect seen while the flushed stages are frozen is remembered until it can land.
  always_comb begin
    flush_pend_d = flush_pend_q;
    if (flush_apply) begin
      flush_pend_d = 1'b0;
    end else if (bus.br_flush) begin
      flush_pend_d = 1'b1;
    end
  end

  always_comb begin
    prev_valid = (valid_q << 1) | STAGES'(1);
    valid_d    = valid_q;
    for (int k = 0; k < STAGES; k++) begin
      if (flush_c[k]) begin
        valid_d[k] = 1'b0;
      end else if (stall_c[k+1]) begin
        valid_d[k] = valid_q[k];
      end else if (bubble_c[k]) begin
        valid_d[k] = 1'b0;
      end else begin
        valid_d[k] = prev_valid[k];
      end
    end
  end

  // The counter keeps running on the completing edge so it reports total busy cycles.
  always_comb begin
    mc_busy_d    = mc_busy_q;
    mc_cnt_d     = mc_cnt_q;
    mc_timeout_d = 1'b0;
    if (!mc_busy_q) begin
      if (bus.mc_start) begin
        mc_busy_d = 1'b1;
        mc_cnt_d  = '0;
      end
    end else begin
      if (mc_cnt_q != TimeoutVal) mc_cnt_d = mc_cnt_q + MC_CNT_W'(1);
      if (bus.mc_done) begin
        mc_busy_d = 1'b0;
      end else if (mc_cnt_q == LastVal) begin
        mc_busy_d    = 1'b0;
        mc_timeout_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q      <= '0;
      flush_pend_q <= 1'b0;
      mc_busy_q    <= 1'b0;
      mc_cnt_q     <= '0;
      mc_timeout_q <= 1'b0;
    end else begin
      valid_q      <= valid_d;
      flush_pend_q <= flush_pend_d;
      mc_busy_q    <= mc_busy_d;
      mc_cnt_q     <= mc_cnt_d;
      mc_timeout_q <= mc_timeout_d;
    end
  end

  assign bus.stall       = stall_c;
  assign bus.bubble      = bubble_c;
  assign bus.flush       = flush_c;
  assign bus.stage_valid = valid_q;
  assign bus.mc_busy     = mc_busy_q;
  assign bus.mc_cnt      = mc_cnt_q;
  assign bus.mc_timeout  = mc_timeout_q;

endmodule
